idex_block: RTL and testbench
=============================

IDEX_BLOCK -- requirements
Module: idex_block

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NREG, default 32, register count; register 0 is hard-wired zero.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 SHALL have port CNTEN, input, 1, pipeline advance enable; 0 = hold ID/EX register.
REQ-006 SHALL have port FLUSH, input, 1, branch/jump taken; kill instruction entering ID/EX.
REQ-007 SHALL have port IFIDOUTPC, input, XLEN, PC from the IF/ID stage.
REQ-008 SHALL have port IFIDOUTInst, input, 32, instruction from the IF/ID stage.
REQ-009 SHALL have ports WBEN (input, 1), WBADDR (input, 5), WBDATA (input, XLEN): write-back request, destination, data.
REQ-010 SHALL have outputs IDEXPC, IDEXRS1DATA, IDEXRS2DATA, IDEXIMM (XLEN each): registered PC, operand values, sign-extended immediate.
REQ-011 SHALL have outputs IDEXRD (5), IDEXOP (6), IDEXFUNCT (6): registered destination, opcode, funct.
REQ-012 SHALL have outputs IDEXREGWR, IDEXMEMRD, IDEXMEMWR, IDEXVALID (1 each): registered control flags.
REQ-013 SHALL have output STALL, 1, combinational load-use hazard; upstream IF/ID holds its contents while high.

Function
REQ-014 SHALL decode opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], sign-extended to XLEN.
REQ-015 SHALL decode: R-type (0x00) dest=rd, REGWR=1; addi (0x08) dest=rt, REGWR=1; lw (0x23) dest=rt, REGWR=1, MEMRD=1; sw (0x2B) MEMWR=1; beq (0x04) no write; any other opcode loads a bubble.
REQ-016 SHALL treat rt as a source only for R-type, sw and beq.
REQ-017 SHALL read rs/rt from the register file combinationally; reads of register 0 return 0.
REQ-018 SHALL write WBDATA to WBADDR at the clock edge when WBEN=1 and WBADDR!=0, independent of CNTEN, STALL, FLUSH.
REQ-019 SHALL assert STALL when IDEXVALID & IDEXMEMRD & IDEXRD!=0 & (IDEXRD==rs, or IDEXRD==rt with rt a source).
REQ-020 SHALL, per clock edge, apply priority RST > FLUSH > (CNTEN=0: hold) > STALL > load decoded instruction.
REQ-021 SHALL, on a bubble (FLUSH, STALL, undecodable opcode), load IDEXVALID=IDEXREGWR=IDEXMEMRD=IDEXMEMWR=0, IDEXRD=0; other fields don't-care.
REQ-022 SHALL deliver an instruction present on IFIDOUTInst to ID/EX outputs one cycle later (latency 1); a load-use stall adds exactly one bubble cycle.
REQ-023 SHALL keep STALL de-asserted when IDEXVALID=0, so a stall never persists beyond one cycle.

Reset
REQ-024 SHALL on RST clear all ID/EX outputs to 0 (IDEXVALID=0, STALL=0 as consequence).
REQ-025 SHALL on RST clear all register-file entries to 0; a WBEN in the same cycle is ignored; reset mid-stall discards the stalled instruction.

Configuration
REQ-026 SHALL with WB_BYPASS_EN defined forward WBDATA to a read port when WBEN=1, WBADDR!=0 and WBADDR matches rs/rt in the same cycle.
REQ-027 SHALL without WB_BYPASS_EN return the pre-write register value for a same-cycle read/write collision.

Structure
REQ-028 SHALL place opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ) and field bit positions in shared package idex_pkg.
REQ-029 SHALL implement the register file as sub-module regfile (2 read ports, 1 write port, synchronous reset) including the bypass option.

Verification
REQ-030 SHALL check: RST high 1 cycle -> all outputs 0; read of r1..r31 returns 0.
REQ-031 SHALL check: WB r5=0x0000_1234, then addi r6,r5,-1 (0x20A6FFFF) -> IDEXRS1DATA=0x1234, IDEXIMM=0xFFFF_FFFF, IDEXRD=6, IDEXREGWR=1.
REQ-032 SHALL check: lw r2,0(r1) then add r3,r2,r4 -> STALL=1 one cycle, one bubble (IDEXVALID=0), add follows with IDEXRD=3.
REQ-033 SHALL check: FLUSH=1 with valid sw on input -> IDEXVALID=0, IDEXMEMWR=0 next cycle.
REQ-034 SHALL check: same-cycle WB r7=0xDEAD_BEEF and read of r7 -> 0xDEADBEEF with WB_BYPASS_EN, old value 0 without it.
REQ-035 SHALL check: WBEN to r0 with 0xFFFF_FFFF -> later read of r0 returns 0; CNTEN=0 holds outputs unchanged for 3 cycles.

Source files
------------

// File: rtl/idex_pkg.sv
// Shared decode constants, instruction field positions and control encoding for the ID/EX stage.
package idex_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned RA_W    = 5;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned IMM_W   = 16;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2
  } dest_t;

  typedef struct packed {
    logic  valid;
    logic  regwr;
    logic  memrd;
    logic  memwr;
    logic  rt_src;
    dest_t dest;
  } ctrl_t;

  // Opcode to control flags; unknown opcodes return all-zero (a bubble).
  function automatic ctrl_t decode_ctrl(input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin c.valid = 1'b1; c.regwr = 1'b1; c.rt_src = 1'b1; c.dest = DST_RD; end
      OP_ADDI:  begin c.valid = 1'b1; c.regwr = 1'b1; c.dest = DST_RT; end
      OP_LW:    begin c.valid = 1'b1; c.regwr = 1'b1; c.memrd = 1'b1; c.dest = DST_RT; end
      OP_SW:    begin c.valid = 1'b1; c.memwr = 1'b1; c.rt_src = 1'b1; end
      OP_BEQ:   begin c.valid = 1'b1; c.rt_src = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/idex_block_regfile.sv
// Register file: two combinational read ports, one write port, synchronous reset, r0 reads zero.
// Optional same-cycle write-to-read forwarding when WB_BYPASS_EN is defined.
module regfile
  import idex_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] raddr1,
  input  logic [RA_W-1:0] raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            wen,
  input  logic [RA_W-1:0] waddr,
  input  logic [XLEN-1:0] wdata
);

  localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] regs [NREG];
  logic            wr_ok;

  assign wr_ok = wen && (waddr != '0) && (32'(waddr) < NREG);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0 && 32'(raddr1) < NREG) rdata1 = regs[raddr1[IDX_W-1:0]];
    if (raddr2 != '0 && 32'(raddr2) < NREG) rdata2 = regs[raddr2[IDX_W-1:0]];
`ifdef WB_BYPASS_EN
    if (wr_ok && waddr == raddr1) rdata1 = wdata;
    if (wr_ok && waddr == raddr2) rdata2 = wdata;
`endif
  end

endmodule

// File: rtl/idex_block.sv
// ID stage decode, register read, load-use hazard detection and the ID/EX pipeline register.
// Define WB_BYPASS_EN to forward same-cycle write-back data to the register read ports.
module idex_block
  import idex_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CNTEN,
  input  logic               FLUSH,
  input  logic [XLEN-1:0]    IFIDOUTPC,
  input  logic [INST_W-1:0]  IFIDOUTInst,
  input  logic               WBEN,
  input  logic [RA_W-1:0]    WBADDR,
  input  logic [XLEN-1:0]    WBDATA,
  output logic [XLEN-1:0]    IDEXPC,
  output logic [XLEN-1:0]    IDEXRS1DATA,
  output logic [XLEN-1:0]    IDEXRS2DATA,
  output logic [XLEN-1:0]    IDEXIMM,
  output logic [RA_W-1:0]    IDEXRD,
  output logic [OP_W-1:0]    IDEXOP,
  output logic [FUNCT_W-1:0] IDEXFUNCT,
  output logic               IDEXREGWR,
  output logic               IDEXMEMRD,
  output logic               IDEXMEMWR,
  output logic               IDEXVALID,
  output logic               STALL
);

  logic [OP_W-1:0]    op;
  logic [RA_W-1:0]    rs;
  logic [RA_W-1:0]    rt;
  logic [RA_W-1:0]    rd_field;
  logic [FUNCT_W-1:0] funct;
  logic [XLEN-1:0]    imm;
  logic [RA_W-1:0]    dest;
  ctrl_t              ctrl;
  logic [XLEN-1:0]    rs1_data;
  logic [XLEN-1:0]    rs2_data;
  logic               advance;
  logic               kill;
  logic               unused_shamt;

  assign unused_shamt = ^IFIDOUTInst[10:6];

  always_comb begin
    op       = IFIDOUTInst[OP_MSB:OP_LSB];
    rs       = IFIDOUTInst[RS_MSB:RS_LSB];
    rt       = IFIDOUTInst[RT_MSB:RT_LSB];
    rd_field = IFIDOUTInst[RD_MSB:RD_LSB];
    funct    = IFIDOUTInst[FUNCT_MSB:FUNCT_LSB];
    imm      = XLEN'($signed(IFIDOUTInst[IMM_MSB:IMM_LSB]));
    ctrl     = decode_ctrl(op);
    case (ctrl.dest)
      DST_RD:  dest = rd_field;
      DST_RT:  dest = rt;
      default: dest = '0;
    endcase
  end

  regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk    (CLK),
    .rst    (RST),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .wen    (WBEN),
    .waddr  (WBADDR),
    .wdata  (WBDATA)
  );

  // A load in EX whose target feeds this instruction must wait one cycle; a bubble clears it.
  assign STALL = IDEXVALID && IDEXMEMRD && (IDEXRD != '0) &&
                 ((IDEXRD == rs) || (ctrl.rt_src && IDEXRD == rt));

  // FLUSH updates the register even when CNTEN is low; STALL only acts while advancing.
  assign advance = FLUSH || CNTEN;
  assign kill    = FLUSH || STALL || !ctrl.valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      IDEXPC      <= '0;
      IDEXRS1DATA <= '0;
      IDEXRS2DATA <= '0;
      IDEXIMM     <= '0;
      IDEXRD      <= '0;
      IDEXOP      <= '0;
      IDEXFUNCT   <= '0;
      IDEXREGWR   <= 1'b0;
      IDEXMEMRD   <= 1'b0;
      IDEXMEMWR   <= 1'b0;
      IDEXVALID   <= 1'b0;
    end else if (advance) begin
      IDEXPC      <= IFIDOUTPC;
      IDEXRS1DATA <= rs1_data;
      IDEXRS2DATA <= rs2_data;
      IDEXIMM     <= imm;
      IDEXOP      <= op;
      IDEXFUNCT   <= funct;
      IDEXRD      <= kill ? '0 : dest;
      IDEXREGWR   <= !kill && ctrl.regwr;
      IDEXMEMRD   <= !kill && ctrl.memrd;
      IDEXMEMWR   <= !kill && ctrl.memwr;
      IDEXVALID   <= !kill;
    end
  end

endmodule

// File: tb/tb_idex_block.sv
// Scoreboard bench for idex_block: a behavioural model pushes expected ID/EX contents per cycle.
module tb_idex_block;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CNTEN;
  logic        FLUSH;
  logic [31:0] IFIDOUTPC;
  logic [31:0] IFIDOUTInst;
  logic        WBEN;
  logic [4:0]  WBADDR;
  logic [31:0] WBDATA;
  logic [31:0] IDEXPC;
  logic [31:0] IDEXRS1DATA;
  logic [31:0] IDEXRS2DATA;
  logic [31:0] IDEXIMM;
  logic [4:0]  IDEXRD;
  logic [5:0]  IDEXOP;
  logic [5:0]  IDEXFUNCT;
  logic        IDEXREGWR;
  logic        IDEXMEMRD;
  logic        IDEXMEMWR;
  logic        IDEXVALID;
  logic        STALL;

  idex_block #(.XLEN(32), .NREG(32)) dut (
    .CLK(CLK), .RST(RST), .CNTEN(CNTEN), .FLUSH(FLUSH),
    .IFIDOUTPC(IFIDOUTPC), .IFIDOUTInst(IFIDOUTInst),
    .WBEN(WBEN), .WBADDR(WBADDR), .WBDATA(WBDATA),
    .IDEXPC(IDEXPC), .IDEXRS1DATA(IDEXRS1DATA), .IDEXRS2DATA(IDEXRS2DATA),
    .IDEXIMM(IDEXIMM), .IDEXRD(IDEXRD), .IDEXOP(IDEXOP), .IDEXFUNCT(IDEXFUNCT),
    .IDEXREGWR(IDEXREGWR), .IDEXMEMRD(IDEXMEMRD), .IDEXMEMWR(IDEXMEMWR),
    .IDEXVALID(IDEXVALID), .STALL(STALL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        regwr;
    logic        memrd;
    logic        memwr;
    logic        valid;
    bit          full;
  } exp_t;

  exp_t        q[$];
  exp_t        m_out;
  logic [31:0] m_reg [32];
  logic [31:0] pc_ctr;
  logic        last_stall;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit wen,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wen && wa == a) return wd;
`endif
    return m_reg[a];
  endfunction

  function automatic bit m_stall(input logic [31:0] inst);
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    bit rt_used;
    op = inst[31:26];
    rs = inst[25:21];
    rt = inst[20:16];
    rt_used = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    return m_out.valid && m_out.memrd && (m_out.rd != 5'd0) &&
           ((m_out.rd == rs) || (rt_used && m_out.rd == rt));
  endfunction

  task automatic bubble(inout exp_t e);
    e.valid = 1'b0; e.regwr = 1'b0; e.memrd = 1'b0; e.memwr = 1'b0;
    e.rd = 5'd0; e.full = 1'b0;
  endtask

  // Model one clock edge and queue the expected ID/EX contents after it.
  task automatic step(input bit rst, input bit cnten, input bit flush, input logic [31:0] inst,
                      input bit wben, input logic [4:0] wa, input logic [31:0] wd, input bit stall);
    exp_t nx;
    bit   ok;
    nx = m_out;
    if (rst) begin
      nx = '{default: 0};
      nx.full = 1'b1;
    end else if (flush) begin
      bubble(nx);
    end else if (cnten) begin
      if (stall) begin
        bubble(nx);
      end else begin
        ok = 1'b1;
        nx.regwr = 1'b0; nx.memrd = 1'b0; nx.memwr = 1'b0; nx.rd = 5'd0;
        case (inst[31:26])
          6'h00: begin nx.rd = inst[15:11]; nx.regwr = 1'b1; end
          6'h08: begin nx.rd = inst[20:16]; nx.regwr = 1'b1; end
          6'h23: begin nx.rd = inst[20:16]; nx.regwr = 1'b1; nx.memrd = 1'b1; end
          6'h2B: nx.memwr = 1'b1;
          6'h04: ;
          default: ok = 1'b0;
        endcase
        if (ok) begin
          nx.valid = 1'b1;
          nx.full  = 1'b1;
          nx.pc    = pc_ctr;
          nx.rs1   = m_read(inst[25:21], wben, wa, wd);
          nx.rs2   = m_read(inst[20:16], wben, wa, wd);
          nx.imm   = {{16{inst[15]}}, inst[15:0]};
          nx.op    = inst[31:26];
          nx.funct = inst[5:0];
        end else begin
          bubble(nx);
        end
      end
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    end else if (wben && wa != 5'd0) begin
      m_reg[wa] = wd;
    end
    m_out = nx;
    q.push_back(nx);
  endtask

  task automatic compare_out();
    exp_t e;
    if (q.size() == 0) begin
      check("sb_entry", 32'(q.size()), 32'd1);
      return;
    end
    e = q.pop_front();
    check("valid", 32'(IDEXVALID), 32'(e.valid));
    check("regwr", 32'(IDEXREGWR), 32'(e.regwr));
    check("memrd", 32'(IDEXMEMRD), 32'(e.memrd));
    check("memwr", 32'(IDEXMEMWR), 32'(e.memwr));
    check("rd", 32'(IDEXRD), 32'(e.rd));
    if (e.full) begin
      check("pc", IDEXPC, e.pc);
      check("rs1", IDEXRS1DATA, e.rs1);
      check("rs2", IDEXRS2DATA, e.rs2);
      check("imm", IDEXIMM, e.imm);
      check("op", 32'(IDEXOP), 32'(e.op));
      check("funct", 32'(IDEXFUNCT), 32'(e.funct));
    end
  endtask

  // Drive one cycle just after a falling edge, model it, then compare at the next falling edge.
  task automatic cyc(input bit rst, input bit cnten, input bit flush, input logic [31:0] inst,
                     input bit wben, input logic [4:0] wa, input logic [31:0] wd);
    bit exp_stall;
    RST = rst; CNTEN = cnten; FLUSH = flush;
    IFIDOUTInst = inst; IFIDOUTPC = pc_ctr;
    WBEN = wben; WBADDR = wa; WBDATA = wd;
    #1;
    exp_stall  = m_stall(inst);
    last_stall = STALL;
    if (!rst) check("stall", 32'(STALL), 32'(exp_stall));
    step(rst, cnten, flush, inst, wben, wa, wd, exp_stall);
    pc_ctr = pc_ctr + 32'd4;
    @(negedge CLK);
    compare_out();
  endtask

  task automatic run(input logic [31:0] inst);
    cyc(1'b0, 1'b1, 1'b0, inst, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wb(input logic [31:0] inst, input logic [4:0] wa, input logic [31:0] wd);
    cyc(1'b0, 1'b1, 1'b0, inst, 1'b1, wa, wd);
  endtask

  localparam logic [31:0] NOP     = 32'hFC00_0000;
  localparam logic [31:0] LW_R2   = 32'h8C22_0000;
  localparam logic [31:0] ADD_R3  = 32'h0044_1820;

  initial begin
    logic [31:0] inst;
    logic [5:0]  rop;
    n_checks = 0; n_pass = 0; pc_ctr = 32'h0000_1000;
    m_out = '{default: 0};
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    RST = 1'b1; CNTEN = 1'b0; FLUSH = 1'b0; IFIDOUTPC = '0; IFIDOUTInst = '0;
    WBEN = 1'b0; WBADDR = '0; WBDATA = '0;
    @(negedge CLK);

    // Reset with a concurrent write-back that must be ignored.
    cyc(1'b1, 1'b1, 1'b0, ADD_R3, 1'b1, 5'd9, 32'h0000_0055);
    check("rst_valid", 32'(IDEXVALID), 32'd0);
    check("rst_rs1", IDEXRS1DATA, 32'd0);
    for (int i = 1; i < 32; i++) run({6'h00, 5'(i), 5'(i), 5'd0, 5'd0, 6'h20});

    wb(NOP, 5'd5, 32'h0000_1234);
    wb(NOP, 5'd1, 32'h0000_0100);
    wb(NOP, 5'd2, 32'h0000_2222);
    wb(NOP, 5'd4, 32'h0000_4444);
    check("nop_bubble", 32'(IDEXVALID), 32'd0);
    run(32'h20A6_FFFF);
    check("addi_rs1", IDEXRS1DATA, 32'h0000_1234);
    check("addi_imm", IDEXIMM, 32'hFFFF_FFFF);
    check("addi_rd", 32'(IDEXRD), 32'd6);
    check("addi_regwr", 32'(IDEXREGWR), 32'd1);

    // Load-use: one stall cycle, one bubble, then the add.
    run(LW_R2);
    run(ADD_R3);
    check("lu_stall", 32'(last_stall), 32'd1);
    check("lu_bubble", 32'(IDEXVALID), 32'd0);
    run(ADD_R3);
    check("lu_stall_gone", 32'(last_stall), 32'd0);
    check("lu_add_rd", 32'(IDEXRD), 32'd3);
    check("lu_add_rs1", IDEXRS1DATA, 32'h0000_2222);

    cyc(1'b0, 1'b1, 1'b1, 32'hAC24_0008, 1'b0, 5'd0, 32'd0);
    check("flush_valid", 32'(IDEXVALID), 32'd0);
    check("flush_memwr", 32'(IDEXMEMWR), 32'd0);

    wb(32'h00E0_4020, 5'd7, 32'hDEAD_BEEF);
`ifdef WB_BYPASS_EN
    check("collide_r7", IDEXRS1DATA, 32'hDEAD_BEEF);
`else
    check("collide_r7", IDEXRS1DATA, 32'h0000_0000);
`endif
    run(32'h00E0_4020);
    check("r7_after", IDEXRS1DATA, 32'hDEAD_BEEF);

    wb(NOP, 5'd0, 32'hFFFF_FFFF);
    run(32'h0000_4820);
    check("r0_rs1", IDEXRS1DATA, 32'd0);
    check("r0_rs2", IDEXRS2DATA, 32'd0);

    // Hold for three cycles; write-back still lands.
    run(32'h20AA_0007);
    cyc(1'b0, 1'b0, 1'b0, LW_R2, 1'b1, 5'd11, 32'h0000_000B);
    cyc(1'b0, 1'b0, 1'b0, ADD_R3, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'hAC24_0008, 1'b0, 5'd0, 32'd0);
    check("hold_rd", 32'(IDEXRD), 32'd10);
    check("hold_imm", IDEXIMM, 32'd7);
    run(32'h0160_6020);
    check("hold_wb_r11", IDEXRS1DATA, 32'h0000_000B);

    // Reset during a stall discards the stalled add and clears r2.
    run(LW_R2);
    cyc(1'b1, 1'b1, 1'b0, ADD_R3, 1'b0, 5'd0, 32'd0);
    check("rst_stall_valid", 32'(IDEXVALID), 32'd0);
    run(ADD_R3);
    check("rst_stall_add_rs1", IDEXRS1DATA, 32'd0);

    wb(NOP, 5'd2, 32'h0000_0777);
    run(32'h1022_0004);
    run(LW_R2);
    run(32'hAC62_0004);
    check("lw_sw_stall", 32'(last_stall), 32'd1);
    run(32'hAC62_0004);
    run(LW_R2);
    run(32'h2122_0001);
    check("lw_addi_nostall", 32'(last_stall), 32'd0);
    run(32'h8C20_0000);
    run(32'h0000_4820);
    check("lw_r0_nostall", 32'(last_stall), 32'd0);

    for (int i = 0; i < 100; i++) begin
      case ($urandom_range(0, 6))
        0: rop = 6'h00;
        1: rop = 6'h08;
        2: rop = 6'h23;
        3: rop = 6'h2B;
        4: rop = 6'h04;
        5: rop = 6'h23;
        default: rop = 6'($urandom());
      endcase
      inst = $urandom();
      inst[31:26] = rop;
      inst[25:21] = 5'($urandom_range(0, 7));
      inst[20:16] = 5'($urandom_range(0, 7));
      inst[15:11] = 5'($urandom_range(0, 7));
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 6) != 0), ($urandom_range(0, 9) == 0),
          inst, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
    end

    check("sb_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
